// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the execute-stage ALU and divider
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Sliced down to the divider width at the point of use.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {i_rem[WIDTH-1:0], i_dvd_bit};
    assign w_trial = w_shift - {1'b0, i_divisor};

    // A set top remainder bit means the shifted value already exceeds any divisor.
    assign o_qbit = i_rem[WIDTH] || (w_shift >= {1'b0, i_divisor});
    assign o_rem  = o_qbit ? w_trial : w_shift;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t r_state;
    div_state_t w_state_next;

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rmd;
    logic             r_dz;

    logic             w_accept;
    logic             w_last;
    logic             w_qbit;
    logic [WIDTH:0]   w_rem_next;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == LAST);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = (b == '0) ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The dividend register doubles as the quotient shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rmd  <= '0;
            r_dz   <= 1'b0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_cnt <= '0;
            r_dvd <= a;
            r_dvs <= b;
            if (b == '0) begin
                r_quot <= DIV0_QUOTIENT[WIDTH-1:0];
                r_rmd  <= a;
                r_dz   <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_quot <= {r_dvd[WIDTH-2:0], w_qbit};
                r_rmd  <= w_rem_next[WIDTH-1:0];
                r_dz   <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rmd;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vt[8];

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] last_q  = '0;
    logic [W-1:0] last_r  = '0;
    logic         last_dz = 1'b0;

    function automatic vec_t mk(input int va, input int vb, input int vq, input int vr, input int vdz);
        vec_t v;
        v.a  = W'(va);
        v.b  = W'(vb);
        v.q  = W'(vq);
        v.r  = W'(vr);
        v.dz = (vdz != 0);
        return v;
    endfunction

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        if (yi == 0) begin
            q  = '1;
            r  = x;
            dz = 1'b1;
        end else begin
            q  = W'(xi / yi);
            r  = W'(xi % yi);
            dz = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int poke,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output int nbusy, output int nunstable);
        lat = -1;
        nbusy = 0;
        nunstable = 0;
        q = '0;
        r = '0;
        dz = 1'b0;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (poke > 0 && k == poke) begin
                a = W'(50);
                b = W'(5);
                start = 1'b1;
            end
            if (poke > 0 && k == poke + 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                q = quotient;
                r = remainder;
                dz = div_by_zero;
                break;
            end
            if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_dz) nunstable++;
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                            input int poke);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int lat;
        int nbusy;
        int nunst;
        run_op(ia, ib, poke, q, r, dz, lat, nbusy, nunst);
        chk($sformatf("%s.latency a=%0d b=%0d", tag, ia, ib), lat, (ib == '0) ? 1 : W + 1);
        chk($sformatf("%s.busy_cycles", tag), nbusy, (ib == '0) ? 0 : W);
        chk($sformatf("%s.quotient a=%0d b=%0d", tag, ia, ib), int'(q), int'(eq));
        chk($sformatf("%s.remainder a=%0d b=%0d", tag, ia, ib), int'(r), int'(er));
        chk($sformatf("%s.div_by_zero", tag), int'(dz), int'(edz));
        chk($sformatf("%s.hold_unstable_cycles", tag), nunst, 0);
        last_q  = eq;
        last_r  = er;
        last_dz = edz;
    endtask

    initial begin
        int nd;
        int prev;
        int nunst;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mdz;

        vt[0] = mk(100, 7, 14, 2, 0);
        vt[1] = mk(255, 1, 255, 0, 0);
        vt[2] = mk(5, 9, 0, 5, 0);
        vt[3] = mk(0, 3, 0, 0, 0);
        vt[4] = mk(200, 0, 255, 200, 1);
        vt[5] = mk(9, 3, 3, 0, 0);
        vt[6] = mk(255, 255, 1, 0, 0);
        vt[7] = mk(0, 0, 255, 0, 1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.quotient", int'(quotient), 0);
        chk("reset.remainder", int'(remainder), 0);
        chk("reset.div_by_zero", int'(div_by_zero), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            check_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, 0);
        end

        // start during RUN must be ignored
        check_op("ignored_start", W'(100), W'(7), W'(14), W'(2), 1'b0, 3);
        nd = 0;
        repeat (12) @(negedge clk) if (done) nd++;
        chk("ignored_start.extra_done", nd, 0);

        // start held high: back-to-back operations
        @(negedge clk);
        a = W'(77);
        b = W'(8);
        start = 1'b1;
        @(posedge clk);
        nd = 0;
        prev = 0;
        nunst = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("b2b.gap", k - prev, W + 1);
                chk("b2b.quotient", int'(quotient), 9);
                chk("b2b.remainder", int'(remainder), 5);
                chk("b2b.div_by_zero", int'(div_by_zero), 0);
                prev = k;
                last_q = W'(9);
                last_r = W'(5);
                last_dz = 1'b0;
            end else if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_dz) begin
                nunst++;
            end
            if (k == 36) start = 1'b0;
        end
        chk("b2b.done_count", nd, 4);
        chk("b2b.hold_unstable_cycles", nunst, 0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a = W'(100);
        b = W'(7);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.quotient", int'(quotient), 0);
        chk("midrst.remainder", int'(remainder), 0);
        chk("midrst.div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_q = '0;
        last_r = '0;
        last_dz = 1'b0;
        nd = 0;
        repeat (12) @(negedge clk) if (done || busy) nd++;
        chk("midrst.activity_after_reset", nd, 0);
        check_op("post_reset", W'(100), W'(7), W'(14), W'(2), 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            x = W'($urandom_range(0, 255));
            y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            model(x, y, mq, mr, mdz);
            check_op($sformatf("rand%0d", i), x, y, mq, mr, mdz, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider. It is the inverse datapath to the existing add/shift-left ALU: it works by trial subtraction and shifting, one quotient bit per clock. It sits beside the ALU in the execute stage and serves operations too costly to do combinationally. A start/busy/done handshake lets a controller issue one divide and collect quotient, remainder and a divide-by-zero flag.

Parameters:
WIDTH, 8, operand and result width in bits (dividend, divisor, quotient, remainder).

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  reset; asynchronous, active-low
start  input  1  request a new divide; sampled only when busy=0
a  input  WIDTH  dividend; captured on the accepting edge
b  input  WIDTH  divisor; captured on the accepting edge
busy  output  1  operation in progress; start ignored while high
done  output  1  one-cycle pulse; results valid from this cycle onward
quotient  output  WIDTH  a / b, unsigned
remainder  output  WIDTH  a % b, unsigned
div_by_zero  output  1  set with done when captured b==0

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. The operation in progress is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at edge n, capture a and b. Clear the working remainder (WIDTH+1 bits) and the iteration counter (0..WIDTH-1).
  - If b!=0: go to RUN; busy=1 after edge n.
  - If b==0: go directly to DONE at edge n. Drive quotient = all ones, remainder = a, div_by_zero=1, done=1 after edge n.
- RUN: at each edge, perform one step: shift {rem, dividend} left by 1, trial = rem - {0,b}.
  - If trial is non-negative, rem=trial and the quotient bit is 1; otherwise rem is restored and the quotient bit is 0.
  - WIDTH steps occur at edges n+1 .. n+WIDTH.
  - At edge n+WIDTH, load the quotient/remainder outputs, set div_by_zero=0, done=1, busy=0, and go to DONE.
- Latency: done is high in the cycle after edge n+WIDTH (WIDTH cycles from accept) for b!=0, and in the cycle after edge n for b==0.
- DONE: lasts one cycle, so done is exactly one cycle wide. Next state is IDLE, unless start=1 in this cycle, in which case the new operands are accepted exactly as in IDLE (back-to-back operation).
- quotient, remainder and div_by_zero change only when done rises. They hold their values through IDLE and the whole following RUN.
- start while busy=1 is ignored, with no effect on state or captured operands.
- Arithmetic is unsigned only. Remainder is always < b when b!=0. There is no overflow case: quotient ≤ a.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package (alu_pkg):
  - state enum {IDLE, RUN, DONE}
  - DIV_WIDTH_DEFAULT = 8
  - DIV0_QUOTIENT = all-ones constant
- One natural sub-module, div_step: combinational single iteration.
  - Inputs: rem (WIDTH+1), next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once by seq_divider; the top level holds the FSM, counter and registers.

Test Plan:
- a=100, b=7, start pulsed 1 cycle -> busy high for 8 cycles; done pulses once, 8 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- a=255, b=1 -> quotient=255, remainder=0. Then a=5, b=9 -> quotient=0, remainder=5. Then a=0, b=3 -> quotient=0, remainder=0.
- a=200, b=0 -> done in the cycle after accept, busy never set; quotient=255, remainder=200, div_by_zero=1. A following a=9, b=3 clears div_by_zero, giving quotient=3, remainder=0.
- During a=100, b=7, pulse start with a=50, b=5 at cycle 3 of RUN -> ignored; result is still 14 r2 and exactly one done.
- Hold start=1 continuously with a=77, b=8 -> back-to-back operations, done every 9 cycles, each result 9 r5. Outputs stay stable between done pulses.
- Assert rst_n=0 for 1 cycle at cycle 4 of RUN (a=100, b=7) -> all outputs 0 immediately and state IDLE, no done. A subsequent a=100, b=7 gives 14 r2.
